// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_fifo                                                    |
// | Purpose  : Configurable UART receiver feeding a first-word-fall-through    |
// |            FIFO of characters tagged with parity/framing error flags.      |
// | Options  : UART_RX_MAJORITY_EN - 2-of-3 majority vote on every bit sample. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 50,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          i_Clock,
  input  logic                          reset,
  input  logic                          i_Rx_Serial,
  output logic                          o_Rx_Valid,
  input  logic                          i_Rx_Ready,
  output logic [DATA_BITS-1:0]          o_Rx_Data,
  output logic                          o_Parity_Err,
  output logic                          o_Frame_Err,
  output logic                          o_Overrun,
  input  logic                          i_Clr_Overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Busy
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int c_IDX_W = $clog2(DATA_BITS);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_ENT_W = DATA_BITS + 2;

  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);
  localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_START = 3'd1;
  localparam logic [2:0] c_ST_DATA  = 3'd2;
  localparam logic [2:0] c_ST_PAR   = 3'd3;
  localparam logic [2:0] c_ST_STOP  = 3'd4;
  localparam logic [2:0] c_ST_WAIT  = 3'd5;

  logic                 sync1_q, sync2_q;
  logic [2:0]           state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_IDX_W-1:0]   idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 push_q, push_d;

  logic [c_ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W:0]     count_q, count_d;
  logic                 overrun_q, overrun_d;

  logic                 w_line;
  logic                 w_bit;
  logic                 w_tick;
  logic                 w_par_x;
  logic                 w_fe;
  logic                 w_valid;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;
  logic                 w_ovr_set;
  logic [c_ENT_W-1:0]   w_head;

  assign w_line = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  // Vote over line one cycle before, at, and after the sample point; the
  // "after" value is already visible one stage earlier in the synchroniser.
  logic line_d1_q;

  always_ff @(posedge i_Clock) begin
    if (reset) line_d1_q <= 1'b1;
    else       line_d1_q <= sync2_q;
  end

  assign w_bit = (line_d1_q & sync2_q) | (line_d1_q & sync1_q) | (sync2_q & sync1_q);
`else
  assign w_bit = sync2_q;
`endif

  assign w_tick  = (cnt_q == c_CNT_LAST);
  assign w_par_x = (^data_q) ^ w_bit;
  assign w_fe    = frame_err_q | ~w_bit;

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= c_ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= i_Rx_Serial;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      data_q      <= data_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      push_q      <= push_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    data_d      = data_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    push_d      = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        stop_d = 1'b0;
        if (!w_line) begin
          state_d     = c_ST_START;
          par_err_d   = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      c_ST_START: begin
        if (cnt_q == c_CNT_HALF) begin
          cnt_d   = '0;
          state_d = w_bit ? c_ST_IDLE : c_ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_ST_DATA: begin
        if (w_tick) begin
          cnt_d         = '0;
          data_d[idx_q] = w_bit;
          idx_d         = idx_q + 1'b1;
          if (idx_q == c_IDX_LAST) state_d = (PARITY != 0) ? c_ST_PAR : c_ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_ST_PAR: begin
        if (w_tick) begin
          cnt_d     = '0;
          par_err_d = (PARITY == 1) ? ~w_par_x : w_par_x;
          state_d   = c_ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_ST_STOP: begin
        if (w_tick) begin
          cnt_d       = '0;
          frame_err_d = w_fe;
          if (STOP_BITS == 2 && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            push_d  = 1'b1;
            // A zero character with a framing error is a break: hold off
            // until the line idles so the low level is not re-received.
            state_d = (w_fe && data_q == '0) ? c_ST_WAIT : c_ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_ST_WAIT: begin
        if (w_line) state_d = c_ST_IDLE;
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    o_Busy = (state_q != c_ST_IDLE);
  end

  assign w_valid   = (count_q != '0);
  assign w_full    = (count_q == c_FULL_CNT);
  assign w_pop     = w_valid & i_Rx_Ready;
  assign w_wr      = push_q & (~w_full | w_pop);
  assign w_ovr_set = push_q & w_full & ~w_pop;
  assign w_head    = mem_q[rd_ptr_q];

  always_ff @(posedge i_Clock) begin
    if (w_wr) mem_q[wr_ptr_q] <= {par_err_q, frame_err_q, data_q};
  end

  always_comb begin
    wr_ptr_d  = w_wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = w_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    case ({w_wr, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overrun_d = w_ovr_set ? 1'b1 : (i_Clr_Overrun ? 1'b0 : overrun_q);
  end

  assign o_Rx_Valid   = w_valid;
  assign o_Rx_Data    = w_valid ? w_head[DATA_BITS-1:0] : '0;
  assign o_Frame_Err  = w_valid & w_head[DATA_BITS];
  assign o_Parity_Err = w_valid & w_head[DATA_BITS+1];
  assign o_Overrun    = overrun_q;
  assign o_Fifo_Count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_rx_fifo                                                 |
// | Purpose  : Directed bench for uart_rx_fifo in 8E1, 8O1 and 8N1 builds.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_p = 1'b1, rx_n = 1'b1;
  logic rdy_p = 1'b0, rdy_n = 1'b0;
  logic clr_p = 1'b0, clr_n = 1'b0;

  logic       vld_e, pe_e, fe_e, ovr_e, busy_e;
  logic [7:0] data_e;
  logic [3:0] cnt_e;
  logic       vld_o, pe_o, fe_o, ovr_o, busy_o;
  logic [7:0] data_o;
  logic [3:0] cnt_o;
  logic       vld_n, pe_n, fe_n, ovr_n, busy_n;
  logic [7:0] data_n;
  logic [2:0] cnt_n;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(50), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_e (
    .i_Clock(clk), .reset(rst), .i_Rx_Serial(rx_p), .o_Rx_Valid(vld_e), .i_Rx_Ready(rdy_p),
    .o_Rx_Data(data_e), .o_Parity_Err(pe_e), .o_Frame_Err(fe_e), .o_Overrun(ovr_e),
    .i_Clr_Overrun(clr_p), .o_Fifo_Count(cnt_e), .o_Busy(busy_e));

  uart_rx_fifo #(.CLKS_PER_BIT(50), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_o (
    .i_Clock(clk), .reset(rst), .i_Rx_Serial(rx_p), .o_Rx_Valid(vld_o), .i_Rx_Ready(rdy_p),
    .o_Rx_Data(data_o), .o_Parity_Err(pe_o), .o_Frame_Err(fe_o), .o_Overrun(ovr_o),
    .i_Clr_Overrun(clr_p), .o_Fifo_Count(cnt_o), .o_Busy(busy_o));

  uart_rx_fifo #(.CLKS_PER_BIT(50), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .i_Clock(clk), .reset(rst), .i_Rx_Serial(rx_n), .o_Rx_Valid(vld_n), .i_Rx_Ready(rdy_n),
    .o_Rx_Data(data_n), .o_Parity_Err(pe_n), .o_Frame_Err(fe_n), .o_Overrun(ovr_n),
    .i_Clr_Overrun(clr_n), .o_Fifo_Count(cnt_n), .o_Busy(busy_n));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_n = v;
    else     rx_p = v;
  endtask

  // One 50-cycle bit; optional single-cycle inversion at mid-bit.
  task automatic drive_bit(input bit sel, input logic v, input bit glitch);
    set_line(sel, v);
    if (glitch) begin
      repeat (25) @(posedge clk);
      #1 set_line(sel, ~v);
      @(posedge clk);
      #1 set_line(sel, v);
      repeat (24) @(posedge clk);
    end else begin
      repeat (50) @(posedge clk);
    end
    #1;
  endtask

  task automatic uart_tx(input bit sel, input logic [7:0] d, input bit par_en,
                         input logic par, input logic stop, input bit glitch);
    drive_bit(sel, 1'b0, glitch);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], glitch);
    if (par_en) drive_bit(sel, par, glitch);
    drive_bit(sel, stop, glitch);
  endtask

  task automatic pop(input bit sel);
    if (sel) rdy_n = 1'b1;
    else     rdy_p = 1'b1;
    @(posedge clk);
    #1;
    rdy_n = 1'b0;
    rdy_p = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_vld_n", vld_n, 0);
    chk("rst_data_n", data_n, 0);
    chk("rst_pe_n", pe_n, 0);
    chk("rst_fe_n", fe_n, 0);
    chk("rst_ovr_n", ovr_n, 0);
    chk("rst_cnt_n", cnt_n, 0);
    chk("rst_busy_n", busy_n, 0);
    chk("rst_cnt_e", cnt_e, 0);

    // 0xA5 with parity bit 0: stop sample at edge 528, valid after edge 529
    fork
      uart_tx(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
      begin
        repeat (528) @(posedge clk);
        #1 chk("lat_pre_vld_e", vld_e, 0);
        @(posedge clk);
        #1 chk("lat_post_vld_e", vld_e, 1);
      end
    join
    chk("f1_cnt_e", cnt_e, 1);
    chk("f1_data_e", data_e, 8'hA5);
    chk("f1_pe_e", pe_e, 0);
    chk("f1_fe_e", fe_e, 0);
    chk("f1_pe_o", pe_o, 1);

    // Same data with parity bit 1
    uart_tx(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1 chk("f2_cnt_e", cnt_e, 2);
    pop(1'b0);
    chk("f2_data_e", data_e, 8'hA5);
    chk("f2_pe_e", pe_e, 1);
    chk("f2_pe_o", pe_o, 0);
    chk("f2_data_o", data_o, 8'hA5);
    pop(1'b0);
    chk("f2_cnt_e_drained", cnt_e, 0);

    // 0x3C with low stop bit, line held low 20 bit times
    uart_tx(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (900) @(posedge clk);
    #1 chk("brk_busy_low", busy_n, 1);
    chk("brk_cnt", cnt_n, 2);
    repeat (100) @(posedge clk);
    #1 rx_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("brk_busy_idle", busy_n, 0);
    chk("brk_cnt_after", cnt_n, 2);
    chk("brk_data0", data_n, 8'h3C);
    chk("brk_fe0", fe_n, 1);
    pop(1'b1);
    chk("brk_data1", data_n, 8'h00);
    chk("brk_fe1", fe_n, 1);
    pop(1'b1);
    chk("brk_cnt_drained", cnt_n, 0);

    // 10-cycle low pulse on idle line
    rx_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 rx_n = 1'b1;
    chk("glt_busy_mid", busy_n, 1);
    repeat (20) @(posedge clk);
    #1 chk("glt_busy_end", busy_n, 0);
    chk("glt_cnt", cnt_n, 0);

    // Overflow of the 4-deep FIFO
    for (int i = 1; i <= 5; i++) uart_tx(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1 chk("ovf_cnt", cnt_n, 4);
    chk("ovf_flag", ovr_n, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_pop_data", data_n, 32'(i));
      pop(1'b1);
    end
    chk("ovf_cnt_drained", cnt_n, 0);
    pop(1'b1);
    chk("empty_pop_cnt", cnt_n, 0);
    chk("empty_pop_vld", vld_n, 0);
    chk("ovf_sticky", ovr_n, 1);
    clr_n = 1'b1;
    @(posedge clk);
    #1 clr_n = 1'b0;
    chk("ovf_clr", ovr_n, 0);

    // Reset in the middle of 0x55 with one entry queued
    uart_tx(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1 chk("pre_rst_cnt", cnt_n, 1);
    drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    rx_n = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("pre_rst_busy", busy_n, 1);
    rst  = 1'b1;
    rx_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", busy_n, 0);
    chk("mid_rst_cnt", cnt_n, 0);
    chk("mid_rst_vld", vld_n, 0);
    chk("mid_rst_data", data_n, 0);
    chk("mid_rst_fe", fe_n, 0);
    repeat (600) @(posedge clk);
    #1 chk("mid_rst_no_entry", cnt_n, 0);
    uart_tx(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1 chk("post_rst_cnt", cnt_n, 1);
    chk("post_rst_data", data_n, 8'h66);
    chk("post_rst_fe", fe_n, 0);
    pop(1'b1);

`ifdef UART_RX_MAJORITY_EN
    uart_tx(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1 chk("maj_cnt", cnt_n, 1);
    chk("maj_data", data_n, 8'h66);
    chk("maj_fe", fe_n, 0);
    pop(1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
